slot_encoder: RTL and testbench

SLOT_ENCODER -- requirements
Module: slot_encoder

---
 rtl/slot_encoder_if.sv | 21 ++
 rtl/slot_encoder.sv | 106 ++++++++++
 tb/tb_slot_encoder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/slot_encoder_if.sv
// Slot encoder bus: active-low slot lines in, decoded slot state and change-event handshake out.
interface slot_encoder_if;
  logic [7:0] sel_n;
  logic [3:0] code;
  logic [3:0] count;
  logic       none;
  logic       multi;
  logic       evt_valid;
  logic       evt_ready;
  logic       overrun;

  modport master (
    output sel_n, evt_ready,
    input  code, count, none, multi, evt_valid, overrun
  );

  modport slave (
    input  sel_n, evt_ready,
    output code, count, none, multi, evt_valid, overrun
  );
endinterface

// File: rtl/slot_encoder.sv
// Debounced 8-slot priority encoder with population count and a change-event handshake.
//   state | meaning
//   IDLE  | no unread change, evt_valid low
//   PEND  | change waiting for the consumer, evt_valid high
module slot_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  slot_encoder_if.slave  bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  localparam logic [3:0] CNT_MAX = 4'hF;
  localparam logic [3:0] THRESH = 4'(DEBOUNCE_CYCLES - 1);

  logic [7:0] sync1, sync2, cand, stable;
  logic [3:0] cnt;
  logic       stable_load;
  logic       chg;
  logic [0:0] state;
  logic       overrun_q;
  logic [7:0] active;
  logic [3:0] code_d, count_d, code_q, count_q;
  logic       none_q, multi_q;

  assign stable_load = (cand == sync2) && (cnt >= THRESH) && (cand != stable);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 8'hFF;
      sync2  <= 8'hFF;
      cand   <= 8'hFF;
      cnt    <= 4'd0;
      stable <= 8'hFF;
      chg    <= 1'b0;
    end else begin
      sync1 <= bus.sel_n;
      sync2 <= sync1;
      if (cand != sync2) begin
        cand <= sync2;
        cnt  <= 4'd0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 4'd1;
      end
      if (stable_load) stable <= cand;
      // chg lines the event up with the cycle the decoded outputs update
      chg <= stable_load;
    end
  end

  assign active = ~stable;

  always_comb begin
    code_d  = 4'b1111;
    count_d = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) code_d = 4'(i);
    end
    for (int i = 0; i < 8; i++) begin
      count_d = count_d + {3'b000, active[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= 4'b1111;
      count_q <= 4'd0;
      none_q  <= 1'b1;
      multi_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      count_q <= count_d;
      none_q  <= (count_d == 4'd0);
      multi_q <= (count_d >= 4'd2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (chg) state <= PEND;
        PEND: begin
          if (bus.evt_ready) begin
            // a change landing on the accept cycle is a new event, not an overrun
            overrun_q <= 1'b0;
            if (!chg) state <= IDLE;
          end else if (chg) begin
            overrun_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.code      = code_q;
  assign bus.count     = count_q;
  assign bus.none      = none_q;
  assign bus.multi     = multi_q;
  assign bus.evt_valid = (state == PEND);
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_slot_encoder.sv
// Self-checking bench for slot_encoder: vector table plus hand sequences for glitch, overrun, same-cycle accept and reset.
module tb_slot_encoder;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slot_encoder_if bus ();
  slot_encoder #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] sel_n;
    logic [3:0] code;
    logic [3:0] count;
    logic       none;
    logic       multi;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] s, input logic [3:0] c, input logic [3:0] n,
                       input logic no, input logic mu);
    vec_t v;
    v.sel_n = s; v.code = c; v.count = n; v.none = no; v.multi = mu;
    bus.sel_n = s;
    sb.push_back(v);
  endtask

  task automatic compare_front(input string nm);
    vec_t v;
    if (sb.size() == 0) begin
      chk({nm, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    v = sb.pop_front();
    chk({nm, " code"},  {28'd0, bus.code},  {28'd0, v.code});
    chk({nm, " count"}, {28'd0, bus.count}, {28'd0, v.count});
    chk({nm, " none"},  {31'd0, bus.none},  {31'd0, v.none});
    chk({nm, " multi"}, {31'd0, bus.multi}, {31'd0, v.multi});
  endtask

  // Called #1 after a posedge with evt_valid low; the next posedge is edge 0.
  task automatic wait_evt(input string nm);
    int e = 99;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.evt_valid) begin
        e = k;
        break;
      end
    end
    chk({nm, " latency"}, e, 3 + D);
    compare_front(nm);
  endtask

  task automatic accept(input string nm);
    bus.evt_ready = 1'b1;
    @(posedge clk); #1;
    bus.evt_ready = 1'b0;
    chk({nm, " accept valid"},   {31'd0, bus.evt_valid}, 32'd0);
    chk({nm, " accept overrun"}, {31'd0, bus.overrun},   32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " code"},    {28'd0, bus.code},      32'hF);
    chk({nm, " count"},   {28'd0, bus.count},     32'd0);
    chk({nm, " none"},    {31'd0, bus.none},      32'd1);
    chk({nm, " multi"},   {31'd0, bus.multi},     32'd0);
    chk({nm, " valid"},   {31'd0, bus.evt_valid}, 32'd0);
    chk({nm, " overrun"}, {31'd0, bus.overrun},   32'd0);
  endtask

  initial begin
    bit bad;
    vecs[0] = '{8'hF7, 4'd3,  4'd1, 1'b0, 1'b0};
    vecs[1] = '{8'h5A, 4'd0,  4'd4, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 4'd0,  4'd8, 1'b0, 1'b1};
    vecs[3] = '{8'hFE, 4'd0,  4'd1, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 4'd7,  4'd1, 1'b0, 1'b0};
    vecs[5] = '{8'hC3, 4'd2,  4'd4, 1'b0, 1'b1};
    vecs[6] = '{8'hEF, 4'd4,  4'd1, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 4'hF,  4'd0, 1'b1, 1'b0};

    rst = 1'b1;
    bus.sel_n = 8'hFF;
    bus.evt_ready = 1'b0;
    #23;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // evt_ready in IDLE must be ignored
    bus.evt_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    bus.evt_ready = 1'b0;
    chk("idle ready ignored", {31'd0, bus.evt_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].sel_n, vecs[i].code, vecs[i].count, vecs[i].none, vecs[i].multi);
      wait_evt($sformatf("vec%0d", i));
      accept($sformatf("vec%0d", i));
    end

    // 3-cycle glitch must not pass the debouncer
    bus.sel_n = 8'hBF;
    repeat (3) @(posedge clk); #1;
    bus.sel_n = 8'hFF;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.evt_valid || bus.code != 4'hF) bad = 1'b1;
    end
    chk("glitch ignored", {31'd0, bad}, 32'd0);

    // second change while pending sets overrun
    drive(8'hFE, 4'd0, 4'd1, 1'b0, 1'b0);
    wait_evt("ovr first");
    drive(8'h7F, 4'd7, 4'd1, 1'b0, 1'b0);
    repeat (8) @(posedge clk); #1;
    compare_front("ovr second");
    chk("ovr overrun", {31'd0, bus.overrun},   32'd1);
    chk("ovr valid",   {31'd0, bus.evt_valid}, 32'd1);
    accept("ovr");

    // change landing on the accept cycle stays pending without overrun
    drive(8'hC3, 4'd2, 4'd4, 1'b0, 1'b1);
    wait_evt("same first");
    drive(8'h00, 4'd0, 4'd8, 1'b0, 1'b1);
    repeat (7) @(posedge clk); #1;
    bus.evt_ready = 1'b1;
    @(posedge clk); #1;
    bus.evt_ready = 1'b0;
    chk("same valid",   {31'd0, bus.evt_valid}, 32'd1);
    chk("same overrun", {31'd0, bus.overrun},   32'd0);
    compare_front("same second");
    accept("same");

    // reset mid-debounce with an event pending
    drive(8'hF7, 4'd3, 4'd1, 1'b0, 1'b0);
    wait_evt("rst pre");
    bus.sel_n = 8'hEF;
    repeat (5) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("mid reset");
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    drive(8'hEF, 4'd4, 4'd1, 1'b0, 1'b0);
    wait_evt("post reset");
    accept("post reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
